fetch_prefetch: RTL
===================

// Module: fetch_prefetch
// PURPOSE
//  Instruction-fetch stage upstream of the datapath: owns the PC, issues pipelined
//  requests to instruction memory, buffers returned words in a small in-order queue,
//  and presents {instr, iaddr} to decode with a valid/ready handshake.
//  Redirects on jmp/target_branch from the datapath and discards stale in-flight responses.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC fetched first after reset
//  DEPTH     2              queue entries = max requests in flight (power of 2, >=2)
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   asynchronous, active-high reset
//  jmp            in   1   redirect pulse from datapath, sampled at clk
//  target_branch  in   32  redirect target PC
//  imem_req       out  1   fetch request valid
//  imem_addr      out  32  fetch address (word aligned)
//  imem_gnt       in   1   memory accepts request this cycle (req&gnt = issue)
//  imem_rvalid    in   1   response valid; responses in issue order, >=1 cycle after issue
//  imem_rdata     in   32  response data
//  instr_valid    out  1   queue head valid
//  instr          out  32  queue head instruction word
//  iaddr          out  32  PC of queue head
//  instr_ready    in   1   datapath consumes head (pop on valid&ready)
//  perf_stall_cnt out  32  only with FETCH_PERF_EN
// BEHAVIOUR
//  - Reset (async): fetch_pc=RESET_PC, queue empty, outstanding=0, discard=0;
//    imem_req=0 while rst high, imem_addr=RESET_PC, instr_valid=0, instr=0, iaddr=0.
//  - Credit: imem_req = !rst & !jmp & (count + outstanding < DEPTH); imem_addr = fetch_pc.
//  - Issue (req&gnt): fetch_pc += 4 (mod 2^32, 0xFFFF_FFFC wraps to 0); push fetch_pc
//    into pending-address FIFO; outstanding += 1.
//  - Response (rvalid): if discard>0, drop and discard -= 1; else pop pending address and
//    push {addr, rdata} into queue. Outstanding -= 1 in both cases.
//  - Queue is registered: rvalid at cycle N -> instr_valid at N+1 (min fetch-to-decode 2 cycles).
//  - Credit accounting guarantees no overflow; push and pop in the same cycle are legal
//    at any occupancy. Head outputs stay stable while instr_valid & !instr_ready.
//  - Redirect (jmp=1 at edge): queue flushed (a simultaneous pop is honoured, then flushed);
//    pending-address FIFO cleared; discard = outstanding after this cycle's response, if any;
//    fetch_pc = {target_branch[31:2], 2'b00}. No issue in the jmp cycle (imem_req=0).
//    instr_valid=0 the cycle after jmp.
//  - Back-to-back jmp: each one reloads fetch_pc; discard accumulates all in-flight requests.
//  - Response while outstanding==0: illegal; assertion in sim, ignored in RTL.
//  - Memory shares rst; no pre-reset responses may arrive after rst deasserts.
// CONFIGURATION
//  FETCH_PERF_EN defined: perf_stall_cnt counts cycles with instr_ready & !instr_valid;
//    saturates at 32'hFFFF_FFFF; cleared only by rst.
//  FETCH_PERF_EN undefined: port and counter absent; all other behaviour identical.
// TESTING
//  1. rst release, gnt=1 always, rvalid 1 cycle after issue, ready=1 -> imem_addr 0,4,8...;
//     first instr_valid 2 cycles after first issue with iaddr=0, then one per cycle.
//  2. ready=0 held, DEPTH=2 -> exactly 2 issues, imem_req drops, instr/iaddr=0x0 stable.
//  3. 2 in flight (0x8,0xC), jmp with target_branch=0x100 -> both responses dropped,
//     next imem_addr=0x100, next delivered iaddr=0x100.
//  4. jmp target_branch=0x103 -> imem_addr=0x100.
//  5. RESET_PC=32'hFFFF_FFFC -> issues 0xFFFF_FFFC then 0x0000_0000.
//  6. rst asserted mid-burst with 2 in flight -> outputs at reset values immediately
//     (async), fetch restarts at RESET_PC after release.
//  (FETCH_PERF_EN) gnt=0 for 10 cycles with ready=1 -> perf_stall_cnt advances by >=10.

Source files
------------

// File: rtl/fetch_prefetch.sv
// Fetch stage: PC ownership, pipelined imem requests, in-order prefetch queue.
// Optional FETCH_PERF_EN adds a saturating decode-starve counter port.
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jmp,
  input  logic [31:0] target_branch,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] iaddr,
  input  logic        instr_ready
`ifdef FETCH_PERF_EN
  , output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef logic [AW-1:0] ptr_t;
  typedef logic [CW-1:0] cnt_t;

  logic [31:0] fetch_pc;

  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_addr  [DEPTH];
  ptr_t        q_rd;
  ptr_t        q_wr;
  cnt_t        q_cnt;

  logic [31:0] p_addr [DEPTH];
  ptr_t        p_rd;
  ptr_t        p_wr;
  cnt_t        outstanding;
  cnt_t        discard;

  logic        issue;
  logic        resp;
  logic        drop;
  logic        accept;
  logic        push;
  logic        pop;
  logic [CW:0] credit_used;
  logic        unused_tb_bits;

  assign unused_tb_bits = ^target_branch[1:0];

  // Queue slots are reserved at issue time so a response always fits.
  assign credit_used = {1'b0, q_cnt} + {1'b0, outstanding};
  assign imem_req    = !rst && !jmp && (credit_used < DEPTH_W);
  assign imem_addr   = fetch_pc;

  assign issue  = imem_req && imem_gnt;
  assign resp   = imem_rvalid && (outstanding != '0);
  assign drop   = resp && (discard != '0);
  assign accept = resp && (discard == '0);
  assign push   = accept && !jmp;
  assign pop    = instr_valid && instr_ready;

  assign instr_valid = (q_cnt != '0);
  assign instr       = q_instr[q_rd];
  assign iaddr       = q_addr[q_rd];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
    end else if (jmp) begin
      fetch_pc <= {target_branch[31:2], 2'b00};
    end else if (issue) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) begin
      p_addr[p_wr] <= fetch_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_rd <= '0;
      p_wr <= '0;
    end else if (jmp) begin
      p_rd <= '0;
      p_wr <= '0;
    end else begin
      if (issue)  p_wr <= p_wr + ptr_t'(1);
      if (accept) p_rd <= p_rd + ptr_t'(1);
    end
  end

  // Everything still in flight after a redirect belongs to the old path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + cnt_t'(issue) - cnt_t'(resp);
      if (jmp) begin
        discard <= outstanding - cnt_t'(resp);
      end else if (drop) begin
        discard <= discard - cnt_t'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        q_instr[i] <= '0;
        q_addr[i]  <= '0;
      end
    end else if (jmp) begin
      q_rd  <= '0;
      q_wr  <= '0;
      q_cnt <= '0;
    end else begin
      if (push) begin
        q_instr[q_wr] <= imem_rdata;
        q_addr[q_wr]  <= p_addr[p_rd];
        q_wr          <= q_wr + ptr_t'(1);
      end
      if (pop) q_rd <= q_rd + ptr_t'(1);
      q_cnt <= q_cnt + cnt_t'(push) - cnt_t'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= '0;
    end else if (instr_ready && !instr_valid && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (rst) imem_rvalid |-> (outstanding != '0)
  );

endmodule
